// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between IFU, the ALU-control decode stage and EXU.
// "slave" is the decode stage itself. "master" is the environment that feeds it and drains it.
interface alu_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_alu_ctrl;
  logic            out_word;
  logic            out_illegal;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_ctrl, out_word, out_illegal, out_inst, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_alu_ctrl, out_word, out_illegal, out_inst, out_pc
  );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered ALU-control decode: one instruction per transfer, one output register,
// full throughput, synchronous flush. The decoder covers RV32I/RV64I and optionally M.
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0,
  parameter int PC_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  alu_decode_stage_if.slave bus
);
  localparam bit IS64 = (XLEN == 64);
  localparam bit M_EN = (HAS_M != 0);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       word;
    logic       ill;
  } dec_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  dec_t       dec;

  assign opc = bus.in_inst[6:0];
  assign f3  = bus.in_inst[14:12];
  assign f7  = bus.in_inst[31:25];

  always_comb begin
    dec = '0;
    case (opc)
      OP_LUI:                                 dec.ctrl = 5'd1;
      OP_AUIPC, OP_JAL, OP_FENCE, OP_SYSTEM:  dec.ctrl = 5'd0;
      OP_JALR: begin
        dec.ctrl = 5'd3;
        dec.ill  = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        case (f3)
          3'b000:  dec.ctrl = 5'd13;
          3'b001:  dec.ctrl = 5'd18;
          3'b100:  dec.ctrl = 5'd16;
          3'b101:  dec.ctrl = 5'd14;
          3'b110:  dec.ctrl = 5'd17;
          3'b111:  dec.ctrl = 5'd15;
          default: dec.ill  = 1'b1;
        endcase
      end
      // ld / lwu / sd only exist on RV64
      OP_LOAD: begin
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec.ill = 1'b0;
          3'b011, 3'b110:                         dec.ill = !IS64;
          default:                                dec.ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        case (f3)
          3'b000, 3'b001, 3'b010: dec.ill = 1'b0;
          3'b011:                 dec.ill = !IS64;
          default:                dec.ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        case (f3)
          3'b000: dec.ctrl = 5'd0;
          3'b010: dec.ctrl = 5'd12;
          3'b011: dec.ctrl = 5'd4;
          3'b100: dec.ctrl = 5'd5;
          3'b110: dec.ctrl = 5'd6;
          3'b111: dec.ctrl = 5'd7;
          3'b001: begin
            dec.ctrl = 5'd19;
            dec.ill  = (f7[6:1] != 6'b000000) || (!IS64 && f7[0]);
          end
          default: begin
            if (f7[6:1] == 6'b000000)      dec.ctrl = 5'd21;
            else if (f7[6:1] == 6'b010000) dec.ctrl = 5'd20;
            else                           dec.ill  = 1'b1;
            if (!IS64 && f7[0]) dec.ill = 1'b1;
          end
        endcase
      end
      OP_OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.ctrl = 5'd0;
            3'b001:  dec.ctrl = 5'd8;
            3'b010:  dec.ctrl = 5'd12;
            3'b011:  dec.ctrl = 5'd4;
            3'b100:  dec.ctrl = 5'd5;
            3'b101:  dec.ctrl = 5'd10;
            3'b110:  dec.ctrl = 5'd6;
            default: dec.ctrl = 5'd7;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec.ctrl = 5'd2;
            3'b101:  dec.ctrl = 5'd9;
            default: dec.ill  = 1'b1;
          endcase
        end else if (f7 == 7'b0000001 && M_EN) begin
          // M codes 22..29 follow funct3 order
          dec.ctrl = 5'd22 + {2'b00, f3};
        end else begin
          dec.ill = 1'b1;
        end
      end
      OP_IMM32: begin
        dec.word = 1'b1;
        if (!IS64) dec.ill = 1'b1;
        else begin
          case (f3)
            3'b000: dec.ctrl = 5'd0;
            3'b001: begin
              dec.ctrl = 5'd19;
              dec.ill  = (f7 != 7'b0000000);
            end
            3'b101: begin
              if (f7 == 7'b0000000)      dec.ctrl = 5'd21;
              else if (f7 == 7'b0100000) dec.ctrl = 5'd20;
              else                       dec.ill  = 1'b1;
            end
            default: dec.ill = 1'b1;
          endcase
        end
      end
      OP_OP32: begin
        dec.word = 1'b1;
        if (!IS64) dec.ill = 1'b1;
        else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.ctrl = 5'd0;
            3'b001:  dec.ctrl = 5'd8;
            3'b101:  dec.ctrl = 5'd10;
            default: dec.ill  = 1'b1;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec.ctrl = 5'd2;
            3'b101:  dec.ctrl = 5'd9;
            default: dec.ill  = 1'b1;
          endcase
        end else if (f7 == 7'b0000001 && M_EN) begin
          case (f3)
            3'b000:  dec.ctrl = 5'd22;
            3'b100:  dec.ctrl = 5'd26;
            3'b101:  dec.ctrl = 5'd27;
            3'b110:  dec.ctrl = 5'd28;
            3'b111:  dec.ctrl = 5'd29;
            default: dec.ill  = 1'b1;
          endcase
        end else begin
          dec.ill = 1'b1;
        end
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.ctrl = 5'd0;
      dec.word = 1'b0;
    end
  end

  // Output register
  logic            out_valid_q, out_valid_d;
  dec_t            dec_q, dec_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            in_ready, capture;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign capture  = bus.in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    if (capture) begin
      out_valid_d = 1'b1;
      dec_d       = dec;
      inst_d      = bus.in_inst;
      pc_d        = bus.in_pc;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_alu_ctrl = dec_q.ctrl;
  assign bus.out_word     = dec_q.word;
  assign bus.out_illegal  = dec_q.ill;
  assign bus.out_inst     = inst_q;
  assign bus.out_pc       = pc_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench: two decode stages (RV64+M and RV32 without M) run from the same stimulus.
// Expected decodes come from a hand-written table.
module tb_alu_decode_stage;
  localparam int N = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_decode_stage_if #(.PC_W(32)) b64 ();
  alu_decode_stage_if #(.PC_W(32)) b32 ();

  alu_decode_stage #(.XLEN(64), .HAS_M(1), .PC_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave));
  alu_decode_stage #(.XLEN(32), .HAS_M(0), .PC_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  c64;
    logic        w64, i64;
    logic [4:0]  c32;
    logic        w32, i32;
  } sb_t;

  sb_t        q[$];
  sb_t        cur;
  logic [45:0] tbl [N];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_out   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [45:0] row(input logic [31:0] inst,
                                      input logic [4:0] c64, input logic w64, input logic i64,
                                      input logic [4:0] c32, input logic w32, input logic i32);
    return {inst, c64, w64, i64, c32, w32, i32};
  endfunction

  task automatic set_in(input logic v, input int i);
    logic [45:0] r;
    r = tbl[i];
    cur.inst = r[45:14];
    cur.pc   = 32'h1000 + 32'(i * 4);
    cur.c64  = r[13:9];
    cur.w64  = r[8];
    cur.i64  = r[7];
    cur.c32  = r[6:2];
    cur.w32  = r[1];
    cur.i32  = r[0];
    b64.in_valid = v;        b32.in_valid = v;
    b64.in_inst  = cur.inst; b32.in_inst  = cur.inst;
    b64.in_pc    = cur.pc;   b32.in_pc    = cur.pc;
  endtask

  task automatic set_rdy(input logic r);
    b64.out_ready = r;
    b32.out_ready = r;
  endtask

  // Drive entry i until the stage accepts it; returns 1ns after the capturing edge.
  task automatic send(input int i);
    logic acc;
    acc = 1'b0;
    set_in(1'b1, i);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = b64.in_ready && !flush;
      @(posedge clk); #1;
    end
    chk("send_accept", acc, 1);
  endtask

  task automatic chk_zero();
    chk("rst_v64", b64.out_valid, 0);    chk("rst_v32", b32.out_valid, 0);
    chk("rst_c64", b64.out_alu_ctrl, 0); chk("rst_c32", b32.out_alu_ctrl, 0);
    chk("rst_w64", b64.out_word, 0);     chk("rst_w32", b32.out_word, 0);
    chk("rst_i64", b64.out_illegal, 0);  chk("rst_i32", b32.out_illegal, 0);
    chk("rst_inst64", b64.out_inst, 0);  chk("rst_inst32", b32.out_inst, 0);
    chk("rst_pc64", b64.out_pc, 0);      chk("rst_pc32", b32.out_pc, 0);
    chk("rst_rdy", b64.in_ready, 1);
  endtask

  // Scoreboard: pop on output handshake, push on capture, drop on flush/reset.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) q.delete();
    else begin
      if (b64.out_ready && (b64.out_valid || b32.out_valid)) begin
        chk("v64", b64.out_valid, 1);
        chk("v32", b32.out_valid, 1);
        chk("sb_underflow", q.size() == 0, 0);
        if (q.size() != 0) begin
          e = q.pop_front();
          n_out++;
          chk("ctrl64", b64.out_alu_ctrl, e.c64);
          chk("word64", b64.out_word, e.w64);
          chk("ill64",  b64.out_illegal, e.i64);
          chk("inst64", b64.out_inst, e.inst);
          chk("pc64",   b64.out_pc, e.pc);
          chk("ctrl32", b32.out_alu_ctrl, e.c32);
          chk("word32", b32.out_word, e.w32);
          chk("ill32",  b32.out_illegal, e.i32);
          chk("inst32", b32.out_inst, e.inst);
          chk("pc32",   b32.out_pc, e.pc);
        end
      end
      if (flush) q.delete();
      else if (b64.in_valid && b64.in_ready) q.push_back(cur);
    end
  end

  initial begin
    time t0;
    time t1;
    //               inst          RV64+M           RV32
    tbl[0]  = row(32'h003100B3, 5'd0,  0, 0, 5'd0,  0, 0); // add
    tbl[1]  = row(32'h403100B3, 5'd2,  0, 0, 5'd2,  0, 0); // sub
    tbl[2]  = row(32'h023100B3, 5'd22, 0, 0, 5'd0,  0, 1); // mul
    tbl[3]  = row(32'h003100BB, 5'd0,  1, 0, 5'd0,  0, 1); // addw
    tbl[4]  = row(32'h42115093, 5'd20, 0, 0, 5'd0,  0, 1); // srai shamt 33
    tbl[5]  = row(32'h00208063, 5'd13, 0, 0, 5'd13, 0, 0); // beq
    tbl[6]  = row(32'h000010B7, 5'd1,  0, 0, 5'd1,  0, 0); // lui
    tbl[7]  = row(32'h0000B083, 5'd0,  0, 0, 5'd0,  0, 1); // ld
    tbl[8]  = row(32'h00112023, 5'd0,  0, 0, 5'd0,  0, 0); // sw
    tbl[9]  = row(32'h00202063, 5'd0,  0, 1, 5'd0,  0, 1); // branch f3=010
    tbl[10] = row(32'h0FF0000F, 5'd0,  0, 0, 5'd0,  0, 0); // fence
    tbl[11] = row(32'h00000073, 5'd0,  0, 0, 5'd0,  0, 0); // ecall
    tbl[12] = row(32'h0011B093, 5'd4,  0, 0, 5'd4,  0, 0); // sltiu
    tbl[13] = row(32'h00112093, 5'd12, 0, 0, 5'd12, 0, 0); // slti
    tbl[14] = row(32'h00117093, 5'd7,  0, 0, 5'd7,  0, 0); // andi
    tbl[15] = row(32'h0231D0B3, 5'd27, 0, 0, 5'd0,  0, 1); // divu
    tbl[16] = row(32'h0231F0B3, 5'd29, 0, 0, 5'd0,  0, 1); // remu
    tbl[17] = row(32'h4031D0BB, 5'd9,  1, 0, 5'd0,  0, 1); // sraw
    tbl[18] = row(32'h0211109B, 5'd0,  0, 1, 5'd0,  0, 1); // slliw shamt[5]=1
    tbl[19] = row(32'h4011509B, 5'd20, 1, 0, 5'd0,  0, 1); // sraiw
    tbl[20] = row(32'hFFFFFFFF, 5'd0,  0, 1, 5'd0,  0, 1); // garbage
    tbl[21] = row(32'h01F11093, 5'd19, 0, 0, 5'd19, 0, 0); // slli 31
    tbl[22] = row(32'h023110B3, 5'd23, 0, 0, 5'd0,  0, 1); // mulh
    tbl[23] = row(32'h0020E063, 5'd17, 0, 0, 5'd17, 0, 0); // bltu
    tbl[24] = row(32'h0000E083, 5'd0,  0, 0, 5'd0,  0, 1); // lwu
    tbl[25] = row(32'h4031C0B3, 5'd0,  0, 1, 5'd0,  0, 1); // f7=0100000 with xor
    tbl[26] = row(32'h0031D0B3, 5'd10, 0, 0, 5'd10, 0, 0); // srl

    set_in(1'b0, 0);
    set_rdy(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back stream: one accept per cycle
    t0 = $time;
    for (int i = 0; i < N; i++) send(i);
    t1 = $time;
    chk("stream_cycles", 64'((t1 - t0) / 10), N);
    set_in(1'b0, 0);
    repeat (2) begin @(posedge clk); #1; end

    // Backpressure: beq held while a new entry waits
    set_rdy(1'b0);
    send(5);
    set_in(1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", b64.out_valid, 1);
      chk("bp_ctrl", b64.out_alu_ctrl, 13);
      chk("bp_inst", b64.out_inst, 32'h00208063);
      chk("bp_ready", b64.in_ready, 0);
      @(posedge clk); #1;
    end
    set_rdy(1'b1);
    @(posedge clk); #1;
    set_in(1'b0, 0);
    @(negedge clk);
    chk("bp_next_valid", b64.out_valid, 1);
    chk("bp_next_ctrl", b64.out_alu_ctrl, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", b64.out_valid, 0);
    @(posedge clk); #1;

    // Flush kills the held entry and the same-cycle capture
    set_rdy(1'b0);
    send(0);
    set_in(1'b1, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    set_in(1'b0, 0);
    @(negedge clk);
    chk("flush_v64", b64.out_valid, 0);
    chk("flush_v32", b32.out_valid, 0);
    @(posedge clk); #1;

    // Reset mid-stall: outputs clear immediately, away from any edge
    send(2);
    set_in(1'b1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1'b0, 0);
    set_rdy(1'b1);
    send(0);
    set_in(1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end

    chk("sb_empty", q.size(), 0);
    chk("outputs_seen", n_out, N + 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
